ds_frame_tx: RTL and testbench
==============================

// Module: ds_frame_tx
// PURPOSE
//  Transmitter for the d/s strobe interface consumed by the FSM receiver.
//  - Accepts one parallel word through a valid/ready handshake.
//  - Serialises the word onto data line d and qualifies each bit with a one-cycle strobe s.
//  - Sits between the host/control logic and the receiver FSM; the same clk drives both ends.
// PARAMETERS
//  WIDTH    8  data bits per frame (2..16)
//  BIT_CYC  4  clk cycles per bit period (>=2)
//  SETUP    1  cycle within the bit period on which s pulses (1..BIT_CYC-1)
// PORTS
//  clk       in   1      system clock, rising edge
//  rst       in   1      asynchronous, active-low reset
//  tx_data   in   WIDTH  word to send; sampled only on handshake
//  tx_valid  in   1      word available
//  tx_ready  out  1      block idle, can accept
//  d         out  1      serial data line
//  s         out  1      bit strobe; receiver samples d while s=1
//  busy      out  1      frame in progress
//  done      out  1      one-cycle pulse at end of frame
// BEHAVIOUR
//  - One clock domain; reset is asynchronous and active-low. All flops clear immediately when rst=0.
//  - Reset values:
//    - state=IDLE; d=0, s=0, busy=0, done=0.
//    - tx_ready=1: combinational, tx_ready = (state==IDLE).
//  - Handshake: accept on a rising clk edge with tx_valid&&tx_ready. tx_data is latched into shift_reg.
//    - tx_valid while busy is ignored; it is not queued.
//  - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//    - START: d=1, one bit period.
//    - DATA: WIDTH bit periods, LSB first, shift_reg >> 1 per period.
//    - PARITY: see CONFIGURATION.
//    - STOP: d=0, s=0 for one bit period; no strobe.
//  - Bit timer: bit_cnt counts 0..BIT_CYC-1 and wraps. The state advances when bit_cnt==BIT_CYC-1.
//    - idx counts DATA bits 0..WIDTH-1.
//  - Strobe: s=1 exactly when bit_cnt==SETUP in START, DATA or PARITY.
//    - d is stable for the whole bit period. d, s and busy are registered outputs.
//  - Latency: d rises 1 cycle after the accept edge; the first s follows SETUP cycles later.
//  - Frame length: (WIDTH+2)*BIT_CYC cycles, or (WIDTH+3)*BIT_CYC with parity.
//  - done=1 on the cycle IDLE is re-entered; tx_ready rises the same cycle.
//    - Back-to-back: a new accept that cycle starts START on the next edge, with no idle gap.
//  - Reset mid-frame: the frame aborts, outputs return to reset values, nothing is resumed.
// CONFIGURATION
//  DS_TX_PARITY_EN defined:
//    - A PARITY state after DATA drives d = even parity (^tx word) for one bit period, with a strobe.
//  Undefined: no PARITY state; DATA -> STOP directly.
// STRUCTURE
//  - Package ds_if_pkg holds:
//    - state encoding localparams ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP (3-bit).
//    - constants START_LVL=1, STOP_LVL=0, shared with the receiver FSM.
//  - Sub-module ds_bit_timer (BIT_CYC, SETUP):
//    - bit_cnt counter with en/clear inputs.
//    - outputs bit_end and strobe_pt.
//  - Top level: FSM, shift_reg, idx and parity.
// TESTING  (WIDTH=8, BIT_CYC=4, SETUP=1)
//  - Reset: hold rst=0 for 2 cycles -> d=0, s=0, busy=0, done=0, tx_ready=1.
//  - Send 0xA5, no parity:
//    - d per period = 1,1,0,1,0,0,1,0,1,0.
//    - 9 s pulses, at cycles 1,5,...,33 after accept+1.
//    - done at cycle 40.
//  - 0xA5 with DS_TX_PARITY_EN: parity bit=0, 10 s pulses, done at cycle 44.
//  - 0xFF with DS_TX_PARITY_EN: parity bit=0; 0x01: parity bit=1.
//  - tx_valid held high across two words 0x3C, 0xC3:
//    - second accepted on the done cycle.
//    - frames contiguous, 20 strobes total.
//    - tx_valid pulsed mid-frame is ignored.
//  - rst=0 at cycle 17 of a frame: d, s, busy drop at once; after release the next word sends cleanly.

Source files
------------

// File: rtl/ds_if_pkg.sv
// rtl/ds_if_pkg.sv - shared d/s link constants and state encoding
// Used by both the transmitter and the receiver FSM.
package ds_if_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic START_LVL = 1'b1;
  localparam logic STOP_LVL  = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
    S_PARITY = ST_PARITY,
    S_STOP   = ST_STOP
  } ds_state_t;

endpackage

// File: rtl/ds_bit_timer.sv
// rtl/ds_bit_timer.sv - bit period counter for the d/s transmitter
// Flags the last cycle of a bit period and the strobe cycle within it.
module ds_bit_timer #(
  parameter int BIT_CYC = 4,
  parameter int SETUP   = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  output logic bit_end,
  output logic strobe_pt
);

  localparam int CNT_W = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;

  logic [CNT_W-1:0] bit_cnt;

  assign bit_end   = (bit_cnt == CNT_W'(BIT_CYC - 1));
  assign strobe_pt = (bit_cnt == CNT_W'(SETUP));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt <= '0;
    end else if (clear) begin
      bit_cnt <= '0;
    end else if (en) begin
      bit_cnt <= bit_end ? '0 : bit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ds_frame_tx.sv
// rtl/ds_frame_tx.sv - d/s strobe frame transmitter
// Optional parity bit after the data bits when DS_TX_PARITY_EN is defined.
module ds_frame_tx
  import ds_if_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int BIT_CYC = 4,
  parameter int SETUP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             d,
  output logic             s,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = $clog2(WIDTH);

  ds_state_t        state_q, state_n;
  logic [WIDTH-1:0] shift_reg;
  logic [IDX_W-1:0] idx;
  logic             bit_end, strobe_pt;
  logic             accept, last_bit;
  logic             d_n, s_n, done_n, busy_n;
`ifdef DS_TX_PARITY_EN
  logic             par_q;
`endif

  assign tx_ready = (state_q == S_IDLE);
  assign last_bit = (idx == IDX_W'(WIDTH - 1));

  // Counter is held at zero while idle so START always gets a full period.
  ds_bit_timer #(
    .BIT_CYC (BIT_CYC),
    .SETUP   (SETUP)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .en        (state_q != S_IDLE),
    .clear     (state_q == S_IDLE),
    .bit_end   (bit_end),
    .strobe_pt (strobe_pt)
  );

  always_comb begin
    state_n = state_q;
    accept  = 1'b0;
    d_n     = 1'b0;
    s_n     = 1'b0;
    done_n  = 1'b0;
    busy_n  = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          accept  = 1'b1;
          state_n = S_START;
        end
      end
      S_START: begin
        d_n = START_LVL;
        s_n = strobe_pt;
        if (bit_end) state_n = S_DATA;
      end
      S_DATA: begin
        d_n = shift_reg[0];
        s_n = strobe_pt;
        if (bit_end && last_bit) begin
`ifdef DS_TX_PARITY_EN
          state_n = S_PARITY;
`else
          state_n = S_STOP;
`endif
        end
      end
`ifdef DS_TX_PARITY_EN
      S_PARITY: begin
        d_n = par_q;
        s_n = strobe_pt;
        if (bit_end) state_n = S_STOP;
      end
`endif
      S_STOP: begin
        d_n = STOP_LVL;
        if (bit_end) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are registered from the current state, so they trail it by one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      shift_reg <= '0;
      idx       <= '0;
      d         <= 1'b0;
      s         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q <= state_n;
      d       <= d_n;
      s       <= s_n;
      busy    <= busy_n;
      done    <= done_n;
      if (accept) begin
        shift_reg <= tx_data;
        idx       <= '0;
      end else if (state_q == S_DATA && bit_end) begin
        shift_reg <= shift_reg >> 1;
        idx       <= idx + 1'b1;
      end
    end
  end

`ifdef DS_TX_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_q <= 1'b0;
    end else if (accept) begin
      par_q <= ^tx_data;
    end
  end
`endif

endmodule

// File: tb/tb_ds_frame_tx.sv
// tb/tb_ds_frame_tx.sv - self-checking bench for ds_frame_tx
// Honours DS_TX_PARITY_EN the same way as the design.
module tb_ds_frame_tx;

  localparam int WIDTH   = 8;
  localparam int BIT_CYC = 4;
  localparam int SETUP   = 1;
`ifdef DS_TX_PARITY_EN
  localparam int NPER = WIDTH + 3;
`else
  localparam int NPER = WIDTH + 2;
`endif
  localparam int FRAME = NPER * BIT_CYC;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] tx_data = '0;
  logic             tx_valid = 1'b0;
  logic             tx_ready, d, s, busy, done;

  int n_chk = 0;
  int n_fail = 0;
  int strobe_total = 0;

  typedef struct {
    logic [7:0]  word;
    logic [10:0] bits;
    int          strobes;
    int          done_cyc;
  } vec_t;

  vec_t tbl[3];

  ds_frame_tx #(
    .WIDTH   (WIDTH),
    .BIT_CYC (BIT_CYC),
    .SETUP   (SETUP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .d        (d),
    .s        (s),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Line level per bit period, period 0 in bit 0: start, data LSB first, [parity], stop.
  function automatic logic [10:0] model_bits(input logic [7:0] w);
`ifdef DS_TX_PARITY_EN
    return {1'b0, ^w, w, 1'b1};
`else
    return {2'b00, w, 1'b1};
`endif
  endfunction

  // Starts at a negedge with the DUT idle; ends at the negedge of the done cycle.
  task automatic frame(input logic [7:0] w, input logic [10:0] bits, input int exp_strobes,
                       input int exp_done, input bit hold, input bit poke, input string tag);
    int ns;
    int dc;
    int per;
    int pos;
    logic [4:0] exp;
    ns = 0;
    dc = -1;
    chk({tag, " ready_at_start"}, {31'd0, tx_ready}, 32'd1);
    tx_data  = w;
    tx_valid = 1'b1;
    @(posedge clk);
    if (!hold) begin
      #1 tx_valid = 1'b0;
    end
    for (int k = 0; k <= FRAME; k++) begin
      @(negedge clk);
      if (k == 0) begin
        exp = 5'b00000;
      end else begin
        per = (k - 1) / BIT_CYC;
        pos = (k - 1) % BIT_CYC;
        exp[4] = bits[per];
        exp[3] = (pos == SETUP) && (per < NPER - 1);
        exp[2] = 1'b1;
        exp[1] = (k == FRAME);
        exp[0] = (k == FRAME);
      end
      chk($sformatf("%s cyc%0d {d,s,busy,done,ready}", tag, k),
          {27'd0, d, s, busy, done, tx_ready}, {27'd0, exp});
      if (s) begin
        ns++;
        strobe_total++;
      end
      if (done) dc = k;
      if (poke && k == 10) begin
        tx_valid = 1'b1;
        tx_data  = ~w;
      end
      if (poke && k == 11) tx_valid = 1'b0;
    end
    chk({tag, " strobe_count"}, ns, exp_strobes);
    chk({tag, " done_cycle"}, dc, exp_done);
  endtask

  initial begin
`ifdef DS_TX_PARITY_EN
    tbl[0] = '{8'hA5, 11'b0_0_10100101_1, 10, 44};
    tbl[1] = '{8'hFF, 11'b0_0_11111111_1, 10, 44};
    tbl[2] = '{8'h01, 11'b0_1_00000001_1, 10, 44};
`else
    tbl[0] = '{8'hA5, 11'b00_10100101_1, 9, 40};
    tbl[1] = '{8'hFF, 11'b00_11111111_1, 9, 40};
    tbl[2] = '{8'h01, 11'b00_00000001_1, 9, 40};
`endif

    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset {d,s,busy,done,ready}", {27'd0, d, s, busy, done, tx_ready}, 32'h01);
    rst = 1'b1;
    @(negedge clk);
    chk("idle after reset", {27'd0, d, s, busy, done, tx_ready}, 32'h01);

    for (int i = 0; i < 3; i++) begin
      frame(tbl[i].word, tbl[i].bits, tbl[i].strobes, tbl[i].done_cyc, 1'b0, 1'b0,
            $sformatf("tbl%0d", i));
    end

    begin
      int base;
      base = strobe_total;
      frame(8'h3C, model_bits(8'h3C), NPER - 1, FRAME, 1'b1, 1'b0, "b2b_first");
      frame(8'hC3, model_bits(8'hC3), NPER - 1, FRAME, 1'b0, 1'b0, "b2b_second");
      chk("b2b total strobes", strobe_total - base, 2 * (NPER - 1));
    end

    frame(8'h5A, model_bits(8'h5A), NPER - 1, FRAME, 1'b0, 1'b1, "poke");
    @(negedge clk);
    chk("idle after poked frame", {27'd0, d, s, busy, done, tx_ready}, 32'h01);

    tx_data  = 8'h9E;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    repeat (18) @(negedge clk);
    chk("pre-reset {d,busy}", {30'd0, d, busy}, 32'h3);
    rst = 1'b0;
    #1;
    chk("mid-frame reset {d,s,busy,done,ready}", {27'd0, d, s, busy, done, tx_ready}, 32'h01);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    frame(8'h66, model_bits(8'h66), NPER - 1, FRAME, 1'b0, 1'b0, "after_reset");

    repeat (20) begin
      logic [7:0] w;
      w = 8'($urandom_range(0, 255));
      frame(w, model_bits(w), NPER - 1, FRAME, 1'b0, 1'b0, $sformatf("rnd_%02h", w));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
